// File: rtl/fxp_div_pkg.sv
// Shared types and default widths for the iterative fixed-point divider.
package fxp_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DEF_IN_W   = 16;
  localparam int DEF_FRAC_W = 19;

  function automatic int q_w(input int in_w, input int frac_w);
    return in_w + frac_w;
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module fxp_div_step #(
  parameter int IN_W = 16
) (
  input  logic [IN_W:0]   rem,
  input  logic [IN_W-1:0] den,
  input  logic            dbit,
  output logic [IN_W:0]   rem_nxt,
  output logic            qbit
);

  logic [IN_W+1:0] sh;
  logic [IN_W+1:0] den_ext;

  always_comb begin
    sh      = {rem, dbit};
    den_ext = {2'b00, den};
    qbit    = (sh >= den_ext);
    // Remainder stays below den, so the top bit of the difference is always zero.
    rem_nxt = (IN_W+1)'(qbit ? (sh - den_ext) : sh);
  end

endmodule

// File: rtl/fxp_div_iter.sv
// Iterative unsigned Q(IN_W).FRAC_W divider, one quotient bit per clock.
// Define FXP_DIV_ROUND_EN for an extra guard iteration and round-half-up.
module fxp_div_iter
  import fxp_div_pkg::*;
#(
  parameter  int IN_W   = DEF_IN_W,
  parameter  int FRAC_W = DEF_FRAC_W,
  localparam int Q_W    = q_w(IN_W, FRAC_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            recip,
  input  logic [IN_W-1:0] num,
  input  logic [IN_W-1:0] den,
  output logic            ready,
  output logic            done,
  output logic [Q_W-1:0]  quotient,
  output logic            dz
);

`ifdef FXP_DIV_ROUND_EN
  localparam int G_W = 1;
`else
  localparam int G_W = 0;
`endif
  localparam int X_W   = Q_W + G_W;
  localparam int CNT_W = $clog2(X_W);

  state_e           state_q, state_d;
  logic [IN_W:0]    rem_q, rem_d;
  logic [IN_W-1:0]  den_q, den_d;
  logic [X_W-1:0]   dvd_q, dvd_d;
  logic [X_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Q_W-1:0]   quotient_q, quotient_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [IN_W:0]    step_rem;
  logic             step_q;
  logic [IN_W-1:0]  op;
  logic [X_W-1:0]   quo_fin;
  logic [Q_W-1:0]   result;

  fxp_div_step #(.IN_W(IN_W)) u_step (
    .rem     (rem_q),
    .den     (den_q),
    .dbit    (dvd_q[X_W-1]),
    .rem_nxt (step_rem),
    .qbit    (step_q)
  );

  always_comb begin
    op      = recip ? IN_W'(1) : num;
    quo_fin = {quo_q[X_W-2:0], step_q};
`ifdef FXP_DIV_ROUND_EN
    // Low bit is the guard; saturate so all-ones never wraps to zero.
    result  = &quo_fin[X_W-1:1] ? quo_fin[X_W-1:1] : quo_fin[X_W-1:1] + Q_W'(quo_fin[0]);
`else
    result  = quo_fin;
`endif
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    den_d      = den_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    quotient_d = quotient_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        if (start) begin
          den_d = den;
          rem_d = '0;
          quo_d = '0;
          dvd_d = {op, {(FRAC_W + G_W){1'b0}}};
          cnt_d = CNT_W'(X_W - 1);
          if (den == '0) begin
            state_d    = DONE;
            quotient_d = '1;
            dz_d       = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = RUN;
            ready_d = 1'b0;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = quo_fin;
        dvd_d = {dvd_q[X_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d    = DONE;
          quotient_d = result;
          dz_d       = 1'b0;
          done_d     = 1'b1;
          ready_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      den_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      quotient_q <= '0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      den_q      <= den_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      quotient_q <= quotient_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign quotient = quotient_q;
  assign dz       = dz_q;

endmodule
